// File: rtl/baser_test_sequencer_pkg.sv
// ============================================================================
// Module : baser_seq_pkg
// Brief  : Shared types and constant tables for the BASE-R link-test sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package baser_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    MII   = 3'd2,
    DRAIN = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int GEN_STEPS = 3;
  localparam int MII_WORDS = 7;

  localparam logic [3:0] GEN_SEL [GEN_STEPS] = '{4'b0001, 4'b0010, 4'b0000};

  // Each entry is {txc, txd}; the last word is the idle pattern held through drain.
  localparam logic [71:0] MII_SCRIPT [MII_WORDS] = '{
    72'h00_FFFFFFFFFFFFFFFF,
    72'h00_AAAAAAAAAAAAAAAA,
    72'hFF_07070707070707FD,
    72'h01_AAAAAAAAAAAAAAFB,
    72'h00_AAAAAAAAAAAAAAAA,
    72'hFC_0707070707FDAAAA,
    72'hFF_0707070707070707
  };

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/baser_test_sequencer_if.sv
// ============================================================================
// Module : baser_test_sequencer_if
// Brief  : Generator drive / checker counter bundle between sequencer and PCS.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface baser_test_sequencer_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int CONTROL_WIDTH = 8,
  parameter int SEL_WIDTH     = 4,
  parameter int CNT_WIDTH     = 32
);
  logic                     enable;
  logic [1:0]               valid;
  logic [SEL_WIDTH-1:0]     data_sel;
  logic [DATA_WIDTH-1:0]    txd;
  logic [CONTROL_WIDTH-1:0] txc;
  logic [CNT_WIDTH-1:0]     block_count;
  logic [CNT_WIDTH-1:0]     inv_block_count;

  modport master (
    output enable, valid, data_sel, txd, txc,
    input  block_count, inv_block_count
  );

  modport slave (
    input  enable, valid, data_sel, txd, txc,
    output block_count, inv_block_count
  );
endinterface

`default_nettype wire

// File: rtl/baser_test_sequencer_dwell_cnt.sv
// ============================================================================
// Module : baser_seq_dwell_cnt
// Brief  : Loadable down-counter; o_tc flags terminal count (0) while enabled.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module baser_seq_dwell_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Terminal flag ignores i_load so the parent can reload on the same cycle.
  assign o_tc = i_en && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/baser_test_sequencer.sv
// ============================================================================
// Module : baser_test_sequencer
// Brief  : Walks the BASE-R generator through pattern and MII stages, then
//          scores checker counter deltas. Optional stall timeout is enabled
//          with the macro BASER_SEQ_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module baser_test_sequencer
  import baser_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int CONTROL_WIDTH  = 8,
  parameter int SEL_WIDTH      = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int GEN_CYCLES     = 10,
  parameter int MII_CYCLES     = 30,
  parameter int DRAIN_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [CNT_WIDTH-1:0]  i_err_thresh,
  baser_test_sequencer_if.master gen_bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [CNT_WIDTH-1:0]  o_err_blocks,
  output logic [2:0]            o_phase,
  output logic                  o_timeout
);

  localparam int MAX_DWELL = max3(GEN_CYCLES, MII_CYCLES, DRAIN_CYCLES);
  localparam int DWELL_W   = $clog2(MAX_DWELL) + 1;

  state_t                   state_q, state_d;
  logic [2:0]               step_q, step_d;
  logic                     dwell_load, dwell_tc, running, run_start;
  logic [DWELL_W-1:0]       dwell_val;
  logic [CNT_WIDTH-1:0]     base_blk_q, base_blk_d, base_inv_q, base_inv_d;
  logic [CNT_WIDTH-1:0]     d_inv, d_blk;
  logic [71:0]              mii_word;

  logic                     enable_q, enable_d;
  logic [1:0]               valid_q, valid_d;
  logic [SEL_WIDTH-1:0]     data_sel_q, data_sel_d;
  logic [DATA_WIDTH-1:0]    txd_q, txd_d;
  logic [CONTROL_WIDTH-1:0] txc_q, txc_d;
  logic                     busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CNT_WIDTH-1:0]     err_blocks_q, err_blocks_d;

  assign running = (state_q == GEN) || (state_q == MII) || (state_q == DRAIN);
  assign d_inv   = gen_bus.inv_block_count - base_inv_q;
  assign d_blk   = gen_bus.block_count - base_blk_q;

  baser_seq_dwell_cnt #(.WIDTH(DWELL_W)) u_dwell (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_load     (dwell_load),
    .i_load_val (dwell_val),
    .i_en       (running),
    .o_tc       (dwell_tc)
  );

`ifdef BASER_SEQ_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_WIDTH-1:0] prev_blk_q;
  logic                 timeout_q, timeout_d, blk_moved, stall_tc, stall_jump;

  assign blk_moved = (gen_bus.block_count != prev_blk_q);

  // Stall window restarts whenever the checker block count moves.
  baser_seq_dwell_cnt #(.WIDTH(STALL_W)) u_stall (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_load     (!running || blk_moved),
    .i_load_val (STALL_W'(TIMEOUT_CYCLES - 1)),
    .i_en       (running && !blk_moved),
    .o_tc       (stall_tc)
  );

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      prev_blk_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      prev_blk_q <= gen_bus.block_count;
      timeout_q  <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    dwell_load = 1'b0;
    dwell_val  = '0;
    run_start  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d    = GEN;
          step_d     = '0;
          dwell_load = 1'b1;
          dwell_val  = DWELL_W'(GEN_CYCLES - 1);
          run_start  = 1'b1;
        end
      end
      GEN: begin
        if (dwell_tc) begin
          dwell_load = 1'b1;
          if (step_q == 3'(GEN_STEPS - 1)) begin
            state_d   = MII;
            step_d    = '0;
            dwell_val = DWELL_W'(MII_CYCLES - 1);
          end else begin
            step_d    = step_q + 3'd1;
            dwell_val = DWELL_W'(GEN_CYCLES - 1);
          end
        end
      end
      MII: begin
        if (dwell_tc) begin
          dwell_load = 1'b1;
          if (step_q == 3'(MII_WORDS - 1)) begin
            state_d   = DRAIN;
            dwell_val = DWELL_W'(DRAIN_CYCLES - 1);
          end else begin
            step_d    = step_q + 3'd1;
            dwell_val = DWELL_W'(MII_CYCLES - 1);
          end
        end
      end
      DRAIN: begin
        if (dwell_tc) begin
          state_d = CHECK;
        end
      end
      CHECK:   state_d = DONE;
      default: state_d = IDLE;
    endcase
`ifdef BASER_SEQ_TIMEOUT_EN
    stall_jump = 1'b0;
    if (running && stall_tc) begin
      stall_jump = 1'b1;
      state_d    = CHECK;
    end
`endif
    // Abort outranks everything, including a simultaneous start.
    if (i_abort) begin
      state_d    = IDLE;
      step_d     = '0;
      dwell_load = 1'b1;
      dwell_val  = '0;
      run_start  = 1'b0;
    end
  end

  always_comb begin
    mii_word     = '0;
    enable_d     = 1'b0;
    valid_d      = 2'b00;
    data_sel_d   = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_blocks_d = err_blocks_q;
    base_blk_d   = base_blk_q;
    base_inv_d   = base_inv_q;
    case (state_d)
      GEN: begin
        enable_d   = 1'b1;
        valid_d    = 2'b11;
        data_sel_d = SEL_WIDTH'(GEN_SEL[step_d[1:0]]);
        busy_d     = 1'b1;
      end
      MII: begin
        valid_d  = 2'b11;
        mii_word = MII_SCRIPT[step_d];
        busy_d   = 1'b1;
      end
      DRAIN, CHECK: begin
        valid_d  = 2'b11;
        mii_word = MII_SCRIPT[MII_WORDS-1];
        busy_d   = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
    txd_d = DATA_WIDTH'(mii_word[63:0]);
    txc_d = CONTROL_WIDTH'(mii_word[71:64]);
`ifdef BASER_SEQ_TIMEOUT_EN
    timeout_d = timeout_q;
    if (run_start)  timeout_d = 1'b0;
    if (stall_jump) timeout_d = 1'b1;
`endif
    if (run_start) begin
      base_blk_d = gen_bus.block_count;
      base_inv_d = gen_bus.inv_block_count;
      pass_d     = 1'b0;
    end
    if (state_q == CHECK) begin
      err_blocks_d = d_inv;
`ifdef BASER_SEQ_TIMEOUT_EN
      pass_d = (d_inv <= i_err_thresh) && (d_blk != '0) && !timeout_q;
`else
      pass_d = (d_inv <= i_err_thresh) && (d_blk != '0);
`endif
    end
    if (i_abort) begin
      pass_d       = 1'b0;
      err_blocks_d = '0;
      base_blk_d   = '0;
      base_inv_d   = '0;
`ifdef BASER_SEQ_TIMEOUT_EN
      timeout_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      enable_q     <= 1'b0;
      valid_q      <= 2'b00;
      data_sel_q   <= '0;
      txd_q        <= '0;
      txc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_blocks_q <= '0;
      base_blk_q   <= '0;
      base_inv_q   <= '0;
    end else begin
      enable_q     <= enable_d;
      valid_q      <= valid_d;
      data_sel_q   <= data_sel_d;
      txd_q        <= txd_d;
      txc_q        <= txc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_blocks_q <= err_blocks_d;
      base_blk_q   <= base_blk_d;
      base_inv_q   <= base_inv_d;
    end
  end

  assign gen_bus.enable   = enable_q;
  assign gen_bus.valid    = valid_q;
  assign gen_bus.data_sel = data_sel_q;
  assign gen_bus.txd      = txd_q;
  assign gen_bus.txc      = txc_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_pass           = pass_q;
  assign o_err_blocks     = err_blocks_q;
  assign o_phase          = state_q;

endmodule

`default_nettype wire

// File: tb/tb_baser_test_sequencer.sv
// ============================================================================
// Module : tb_baser_test_sequencer
// Brief  : Randomized self-checking bench for baser_test_sequencer (default build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_baser_test_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [31:0] thresh;
  logic        o_busy, o_done, o_pass, o_timeout;
  logic [31:0] o_err_blocks;
  logic [2:0]  o_phase;
  int          checks = 0;
  int          errors = 0;

  logic [63:0] ref_txd [7] = '{64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA, 64'h07070707070707FD,
                               64'hAAAAAAAAAAAAAAFB, 64'hAAAAAAAAAAAAAAAA, 64'h0707070707FDAAAA,
                               64'h0707070707070707};
  logic [7:0]  ref_txc [7] = '{8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 8'hFC, 8'hFF};

  always #5 clk = ~clk;

  baser_test_sequencer_if #(.DATA_WIDTH(64), .CONTROL_WIDTH(8), .SEL_WIDTH(4), .CNT_WIDTH(32)) bus ();

  baser_test_sequencer dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_err_thresh (thresh),
    .gen_bus      (bus),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_pass       (o_pass),
    .o_err_blocks (o_err_blocks),
    .o_phase      (o_phase),
    .o_timeout    (o_timeout)
  );

  // Cycle k counts from the first cycle after the start request was sampled.
  // Run layout: 3 selector steps of 10, 7 script words of 30, 16 drain, 1 check.
  function automatic logic [78:0] exp_drv(input int k);
    logic [78:0] v;
    int idx;
    v = '0;
    if (k >= 1 && k <= 30) begin
      v[78]    = 1'b1;
      v[77:76] = 2'b11;
      v[75:72] = (k <= 10) ? 4'd1 : (k <= 20) ? 4'd2 : 4'd0;
    end else if (k >= 31 && k <= 256) begin
      idx = (k <= 240) ? (k - 31) / 30 : 6;
      v[77:76] = 2'b11;
      v[71:64] = ref_txc[idx];
      v[63:0]  = ref_txd[idx];
    end
    return v;
  endfunction

  function automatic logic [6:0] exp_stat(input int k, input bit p);
    logic [2:0] ph;
    ph = (k >= 1 && k <= 30) ? 3'd1 : (k <= 240 && k >= 31) ? 3'd2 :
         (k >= 241 && k <= 256) ? 3'd3 : (k == 257) ? 3'd4 : (k == 258) ? 3'd5 : 3'd0;
    return {(k >= 1 && k <= 257), (k == 258), (k == 258) ? p : 1'b0, 1'b0, ph};
  endfunction

  task automatic launch(input logic [31:0] blk0, input logic [31:0] inv0, input logic [31:0] thr);
    @(posedge clk); #1;
    bus.block_count     = blk0;
    bus.inv_block_count = inv0;
    thresh              = thr;
    start               = 1'b1;
  endtask

  // Plays one run from the cycle after the start request; optionally kills it
  // (abort or reset) at kill_k, or keeps start high at the DONE cycle.
  task automatic do_run(input int inj_k, input logic [31:0] inj_amt, input bit freeze,
                        input bit noise, input bit hold_start, input int kill_k,
                        input bit kill_rst, input string tag);
    logic [31:0] base_blk, base_inv, thr, d_inv, d_blk;
    logic [6:0]  st_got, st_exp;
    logic [78:0] dv_got, dv_exp;
    logic [31:0] eb_exp;
    bit          exp_pass, killed;
    int          last;
    base_blk = bus.block_count;
    base_inv = bus.inv_block_count;
    thr      = thresh;
    d_inv    = '0;
    d_blk    = '0;
    exp_pass = 1'b0;
    last     = (kill_k > 0) ? kill_k + 4 : 258;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      abort  = 1'b0;
      rst_n  = 1'b1;
      killed = (kill_k > 0) && (k > kill_k);
      if (!killed) begin
        if (!freeze) bus.block_count = bus.block_count + 32'd1;
        if (k == inj_k) bus.inv_block_count = bus.inv_block_count + inj_amt;
        if (k == 258) start = hold_start;
        else if (noise && k <= 257) start = 1'($urandom_range(0, 1));
        if (k == kill_k) begin
          start = 1'b1;
          if (kill_rst) rst_n = 1'b0;
          else abort = 1'b1;
        end
      end
      if (k == 257) begin
        d_inv    = bus.inv_block_count - base_inv;
        d_blk    = bus.block_count - base_blk;
        exp_pass = (d_inv <= thr) && (d_blk != 32'd0);
      end
      @(negedge clk);
      st_got = {o_busy, o_done, o_pass, o_timeout, o_phase};
      dv_got = {bus.enable, bus.valid, bus.data_sel, bus.txc, bus.txd};
      st_exp = killed ? 7'd0 : exp_stat(k, exp_pass);
      dv_exp = killed ? 79'd0 : exp_drv(k);
      checks++;
      if (st_got !== st_exp) begin
        errors++;
        $display("FAIL %s status cyc=%0d got=%b exp=%b (busy,done,pass,tmo,phase)", tag, k, st_got, st_exp);
      end
      if (k != 257) begin
        checks++;
        if (dv_got !== dv_exp) begin
          errors++;
          $display("FAIL %s drives cyc=%0d got=%h exp=%h", tag, k, dv_got, dv_exp);
        end
      end
      if (k == 258 || (killed && k == kill_k + 1)) begin
        eb_exp = killed ? 32'd0 : d_inv;
        checks++;
        if (o_err_blocks !== eb_exp) begin
          errors++;
          $display("FAIL %s err_blocks cyc=%0d got=%0d exp=%0d", tag, k, o_err_blocks, eb_exp);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; thresh = $urandom;
    bus.block_count = $urandom; bus.inv_block_count = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_pass, o_timeout, o_phase, o_err_blocks} !== 39'd0) begin
      errors++;
      $display("FAIL reset_status got=%h exp=0", {o_busy, o_done, o_pass, o_timeout, o_phase, o_err_blocks});
    end
    checks++;
    if ({bus.enable, bus.valid, bus.data_sel, bus.txc, bus.txd} !== 79'd0) begin
      errors++;
      $display("FAIL reset_drives got=%h exp=0", {bus.enable, bus.valid, bus.data_sel, bus.txc, bus.txd});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_busy, o_phase} !== 4'd0) begin
      errors++;
      $display("FAIL reset_release got=%b exp=0000", {o_busy, o_phase});
    end
  endtask

  task automatic test_basic;
    for (int r = 0; r < 2; r++) begin
      launch($urandom, $urandom, 32'd0);
      do_run(-1, 32'd0, 1'b0, 1'b1, 1'b0, 0, 1'b0, "basic");
    end
  endtask

  task automatic test_err_thresh;
    launch($urandom, $urandom, 32'd2);
    do_run(150, 32'd3, 1'b0, 1'b0, 1'b0, 0, 1'b0, "thresh2");
    launch($urandom, $urandom, 32'd3);
    do_run(150, 32'd3, 1'b0, 1'b0, 1'b0, 0, 1'b0, "thresh3");
    for (int r = 0; r < 3; r++) begin
      launch($urandom, $urandom, 32'($urandom_range(0, 4)));
      do_run($urandom_range(1, 257), 32'($urandom_range(0, 5)), 1'b0, 1'b1, 1'b0, 0, 1'b0, "thresh_rand");
    end
  endtask

  task automatic test_wrap;
    launch(32'hFFFFFFF0, 32'hFFFFFFFE, 32'd2);
    do_run(60, 32'd2, 1'b0, 1'b0, 1'b0, 0, 1'b0, "wrap");
  endtask

  task automatic test_frozen;
    launch($urandom, $urandom, 32'd5);
    do_run(-1, 32'd0, 1'b1, 1'b0, 1'b0, 0, 1'b0, "frozen");
  endtask

  task automatic test_abort;
    launch($urandom, $urandom, 32'd0);
    do_run(-1, 32'd0, 1'b0, 1'b0, 1'b0, 130, 1'b0, "abort");
    launch($urandom, $urandom, 32'd0);
    do_run(-1, 32'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, "after_abort");
  endtask

  task automatic test_reset_midrun;
    launch($urandom, $urandom, 32'd0);
    do_run(-1, 32'd0, 1'b0, 1'b0, 1'b0, $urandom_range(1, 250), 1'b1, "rst_mid");
    launch($urandom, $urandom, 32'd0);
    do_run(-1, 32'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back;
    launch($urandom, $urandom, 32'd0);
    do_run(100, 32'd1, 1'b0, 1'b0, 1'b1, 0, 1'b0, "b2b_run1");
    do_run(-1, 32'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, "b2b_run2");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_err_thresh;
    test_wrap;
    test_frozen;
    test_abort;
    test_reset_midrun;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
